imm_extend_ctrl: RTL and testbench

IMM_EXTEND_CTRL -- requirements
Module: imm_extend_ctrl

---
 rtl/imm_extend_ctrl.sv | 136 +++++++++++++
 tb/tb_imm_extend_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imm_extend_ctrl.sv
// LEGv8 immediate extractor: classify, sign/zero-extend and (for branches) scale
// the immediate field with a valid/ready handshake. Define IMM_ERR_COUNT_EN to add err_count.
module imm_extend_ctrl #(
    parameter int BR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] imm,
    output logic [2:0]  kind,
    output logic        err
`ifdef IMM_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [1:0] {IDLE, DECODE, EXTEND, HOLD} state_t;
    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_ALU  = 3'd1,
        K_DT   = 3'd2,
        K_CB   = 3'd3,
        K_B    = 3'd4
    } kind_t;

    state_t      state;
    logic [31:0] instr_q;
    logic [25:0] field_q;
    kind_t       kind_q;
    kind_t       dec_kind;
    logic [25:0] dec_field;
    logic [63:0] ext_imm;
    logic        accept;
    logic        hold_exit;

    // NOTE: in_ready is combinational because a HOLD-state accept must follow
    // out_ready in the same cycle; registering it would cost a bubble.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign hold_exit = (state == HOLD) && out_ready;

    always_comb begin
        dec_kind  = K_NONE;
        dec_field = '0;
        if (instr_q[31:26] == 6'b000101) begin
            dec_kind  = K_B;
            dec_field = instr_q[25:0];
        end else if (instr_q[31:24] == 8'b10110100) begin
            dec_kind  = K_CB;
            dec_field = {7'd0, instr_q[23:5]};
        end else if ((instr_q[31:21] == 11'b11111000010) ||
                     (instr_q[31:21] == 11'b11111000000)) begin
            dec_kind  = K_DT;
            dec_field = {17'd0, instr_q[20:12]};
        end else if (instr_q[31:22] == 10'b1001000100) begin
            dec_kind  = K_ALU;
            dec_field = {14'd0, instr_q[21:10]};
        end
    end

    // Branch offsets are extended to 64 bits first, so the shift drops bits off bit 63.
    always_comb begin
        ext_imm = '0;
        case (kind_q)
            K_B:    ext_imm = {{38{field_q[25]}}, field_q[25:0]} << BR_SHIFT;
            K_CB:   ext_imm = {{45{field_q[18]}}, field_q[18:0]} << BR_SHIFT;
            K_DT:   ext_imm = {{55{field_q[8]}}, field_q[8:0]};
            K_ALU:  ext_imm = {52'd0, field_q[11:0]};
            default: ext_imm = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            instr_q   <= '0;
            field_q   <= '0;
            kind_q    <= K_NONE;
            out_valid <= 1'b0;
            imm       <= '0;
            kind      <= 3'd0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= instr;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    field_q <= dec_field;
                    kind_q  <= dec_kind;
                    state   <= EXTEND;
                end
                EXTEND: begin
                    imm       <= ext_imm;
                    kind      <= kind_q;
                    err       <= (kind_q == K_NONE);
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            instr_q <= instr;
                            state   <= DECODE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMM_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (hold_exit && err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_ctrl.sv
// Directed self-checking bench for imm_extend_ctrl: decode classes, handshake
// stall/back-to-back accept, mid-operation reset, optional error counter.
module tb_imm_extend_ctrl;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic [2:0]  kind;
    logic        err;
`ifdef IMM_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    imm_extend_ctrl #(.BR_SHIFT(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .kind      (kind),
        .err       (err)
`ifdef IMM_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction until accepted; returns with the accept edge just passed.
    task automatic send(input logic [31:0] word, input string tag);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        instr    = word;
        step();
        in_valid = 1'b0;
        instr    = 32'hDEAD_BEEF;
    endtask

    // After the accept edge: DECODE, EXTEND, then HOLD with the result on the third edge.
    task automatic expect_result(input string tag, input logic [63:0] e_imm,
                                 input logic [2:0] e_kind, input logic e_err);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        step();
        check({tag, "_lat2"}, 64'(out_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, imm, e_imm);
        check({tag, "_kind"}, 64'(kind), 64'(e_kind));
        check({tag, "_err"}, 64'(err), 64'(e_err));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [31:0] word, input logic [63:0] e_imm,
                       input logic [2:0] e_kind, input logic e_err, input string tag);
        send(word, tag);
        expect_result(tag, e_imm, e_kind, e_err);
        drain();
        check({tag, "_done"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        #23;
        reset_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm", imm, 64'd0);
        check("rst_kind", 64'(kind), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef IMM_ERR_COUNT_EN
        check("rst_err_count", 64'(err_count), 64'd0);
`endif
        step();

        run(32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0, "b_neg1");
        run(32'h1400_0001, 64'h0000_0000_0000_0004, 3'd4, 1'b0, "b_pos");
        run(32'h913F_FC00, 64'h0000_0000_0000_0FFF, 3'd1, 1'b0, "addi_fff");
        run(32'hF850_0000, 64'hFFFF_FFFF_FFFF_FF00, 3'd2, 1'b0, "ldur_100");
        run(32'hF80F_F000, 64'h0000_0000_0000_00FF, 3'd2, 1'b0, "stur_0ff");
        run(32'hB400_0020, 64'h0000_0000_0000_0004, 3'd3, 1'b0, "cbz_1");
        run(32'hB4FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, "cbz_neg1");
        run(32'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b1, "none_zero");
        run(32'h9140_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b1, "none_near_addi");

        // Consumer stalls for 5 cycles, then releases with a new instruction waiting.
        send(32'h913F_FC00, "stall");
        expect_result("stall", 64'h0000_0000_0000_0FFF, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            instr    = 32'h0000_0000;
            step();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_imm", imm, 64'h0000_0000_0000_0FFF);
            check("stall_kind", 64'(kind), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b1;
        instr     = 32'h1400_0002;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0000_0000;
        expect_result("b2b", 64'h0000_0000_0000_0008, 3'd4, 1'b0);
        drain();

        // Reset pulse while the instruction sits in EXTEND.
        send(32'h17FF_FFFF, "rst_mid");
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_imm", imm, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_mid_no_stale", 64'(out_valid), 64'd0);
            check("rst_mid_idle", 64'(in_ready), 64'd1);
        end
        run(32'hB400_0020, 64'h0000_0000_0000_0004, 3'd3, 1'b0, "post_rst");

`ifdef IMM_ERR_COUNT_EN
        for (int i = 0; i < 260; i++) begin
            send(32'h0000_0000, "sat");
            step();
            step();
            drain();
        end
        check("err_count_sat", 64'(err_count), 64'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
